// File: rtl/systema_btn_mode_pkg.sv
// Shared types and constants for the systema button-mode controller.
package systema_btn_mode_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CLEAR,
    ST_UPDATE,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;

endpackage

// File: rtl/systema_btn_mode_holdoff.sv
// Debounce hold-off timer: `start` loads the window, `done` marks its last cycle.
module systema_btn_mode_holdoff #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Counting down from CYCLES, the value 1 is seen in the final held cycle.
  assign done = (count == CW'(1));

endmodule

// File: rtl/systema_btn_mode_ctrl.sv
// Avalon-MM master servicing the two-button edge-capture PIO and tracking a wrapping mode index.
// Optional debounce hold-off compiled in with BTN_MODE_CTRL_HOLDOFF_EN.
module systema_btn_mode_ctrl
  import systema_btn_mode_pkg::*;
#(
  parameter int         NUM_MODES      = 4,
  parameter int         MODE_W         = 2,
  parameter int         RESET_MODE     = 0,
  parameter logic [1:0] IRQ_MASK_INIT  = 2'b11,
  parameter int         HOLDOFF_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              busy
);

  localparam logic [MODE_W:0] LAST_MODE = (MODE_W + 1)'(NUM_MODES - 1);
  localparam logic [MODE_W:0] ONE_EXT   = (MODE_W + 1)'(1);

  state_t            state;
  state_t            next_state;
  logic [1:0]        cap;
  logic [MODE_W:0]   mode_ext;
  logic [MODE_W:0]   next_ext;
  logic [MODE_W-1:0] next_mode;
  logic [1:0]        nxt_address;
  logic              nxt_chipselect;
  logic              nxt_write_n;
  logic [31:0]       nxt_writedata;
  logic              unused_rd;
  logic              unused_ext_msb;

  assign unused_rd      = ^avm_readdata[31:2];
  assign unused_ext_msb = next_ext[MODE_W];

`ifdef BTN_MODE_CTRL_HOLDOFF_EN
  logic hold_start;
  logic hold_done;

  systema_btn_mode_holdoff #(
    .CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk  (clk),
    .reset(reset),
    .start(hold_start),
    .done (hold_done)
  );
`else
  localparam int unused_holdoff = HOLDOFF_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // INIT stays put until its own mask write is on the bus, so the write is seen inside INIT.
  always_comb begin
    next_state = state;
`ifdef BTN_MODE_CTRL_HOLDOFF_EN
    hold_start = 1'b0;
`endif
    case (state)
      ST_INIT:   if (avm_chipselect) next_state = ST_IDLE;
      ST_IDLE:   if (irq) next_state = ST_READ;
      ST_READ:   next_state = ST_WAIT;
      ST_WAIT:   next_state = ST_CLEAR;
      ST_CLEAR:  next_state = ST_UPDATE;
`ifdef BTN_MODE_CTRL_HOLDOFF_EN
      ST_UPDATE: begin
        next_state = ST_HOLD;
        hold_start = 1'b1;
      end
      ST_HOLD:   if (hold_done) next_state = ST_FLUSH;
      ST_FLUSH:  next_state = ST_IDLE;
`else
      ST_UPDATE: next_state = ST_IDLE;
`endif
      default:   next_state = ST_INIT;
    endcase

    nxt_chipselect = 1'b0;
    nxt_write_n    = 1'b1;
    nxt_address    = ADDR_DATA;
    nxt_writedata  = '0;
    case (next_state)
      ST_INIT: begin
        nxt_chipselect = 1'b1;
        nxt_write_n    = 1'b0;
        nxt_address    = ADDR_MASK;
        nxt_writedata  = 32'(IRQ_MASK_INIT);
      end
      ST_READ: begin
        nxt_chipselect = 1'b1;
        nxt_address    = ADDR_EDGE;
      end
      ST_CLEAR, ST_FLUSH: begin
        nxt_chipselect = 1'b1;
        nxt_write_n    = 1'b0;
        nxt_address    = ADDR_EDGE;
      end
      default: ;
    endcase
  end

  // One extra bit keeps the wrap compares explicit instead of leaning on overflow.
  always_comb begin
    mode_ext = {1'b0, mode};
    next_ext = mode_ext;
    if (cap[BTN_NEXT] && !cap[BTN_PREV]) begin
      next_ext = (mode_ext == LAST_MODE) ? '0 : mode_ext + ONE_EXT;
    end else if (cap[BTN_PREV] && !cap[BTN_NEXT]) begin
      next_ext = (mode_ext == '0) ? LAST_MODE : mode_ext - ONE_EXT;
    end
  end

  assign next_mode = next_ext[MODE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= ADDR_DATA;
      avm_writedata  <= '0;
      busy           <= 1'b1;
      mode           <= MODE_W'(RESET_MODE);
      mode_changed   <= 1'b0;
      cap            <= 2'b00;
    end else begin
      avm_chipselect <= nxt_chipselect;
      avm_write_n    <= nxt_write_n;
      avm_address    <= nxt_address;
      avm_writedata  <= nxt_writedata;
      busy           <= (next_state != ST_IDLE);
      mode_changed   <= 1'b0;
      if (state == ST_WAIT) begin
        cap <= avm_readdata[1:0];
      end
      if (state == ST_UPDATE) begin
        mode         <= next_mode;
        mode_changed <= (next_mode != mode);
      end
    end
  end

endmodule

// File: tb/tb_systema_btn_mode_ctrl.sv
// Directed self-checking bench for systema_btn_mode_ctrl with a behavioural edge-capture PIO.
// Expectations follow BTN_MODE_CTRL_HOLDOFF_EN (HOLDOFF_CYCLES overridden to 16).
`timescale 1ns/1ps
module tb_systema_btn_mode_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic [1:0]  mode;
  logic        mode_changed;
  logic        busy;

  logic [1:0]  press = 2'b00;
  logic [1:0]  pio_edge = 2'b00;
  logic [1:0]  pio_mask = 2'b00;
  logic        spurious = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  int          pulse_cnt = 0;
  int          clear_cnt = 0;

`ifdef BTN_MODE_CTRL_HOLDOFF_EN
  localparam int EXP_BUSY = 21;
  localparam int EXP_CLEARS = 2;
`else
  localparam int EXP_BUSY = 4;
  localparam int EXP_CLEARS = 1;
`endif

  typedef struct {
    logic [1:0] btn;
    logic       spur;
    logic [1:0] exp_mode;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [7] = '{
    '{2'b01, 1'b0, 2'd2, 1},
    '{2'b01, 1'b0, 2'd3, 1},
    '{2'b01, 1'b0, 2'd0, 1},
    '{2'b10, 1'b0, 2'd3, 1},
    '{2'b10, 1'b0, 2'd2, 1},
    '{2'b11, 1'b0, 2'd2, 0},
    '{2'b00, 1'b1, 2'd2, 0}
  };

  systema_btn_mode_ctrl #(
    .NUM_MODES     (4),
    .MODE_W        (2),
    .RESET_MODE    (0),
    .IRQ_MASK_INIT (2'b11),
    .HOLDOFF_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .mode          (mode),
    .mode_changed  (mode_changed),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  assign irq = (|(pio_edge & pio_mask)) | spurious;

  // PIO model: registered read data, filler outside reads, edge register cleared by writes to offset 3.
  always @(posedge clk) begin
    if (reset) begin
      pio_mask <= 2'b00;
    end else if (avm_chipselect && !avm_write_n && avm_address == 2'd2) begin
      pio_mask <= avm_writedata[1:0];
    end
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
      pio_edge  <= 2'b00;
      clear_cnt <= clear_cnt + 1;
    end else begin
      pio_edge <= pio_edge | press;
    end
    avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 2'd3) ?
                    {30'd0, pio_edge} : 32'hA5A5_A5A6;
    if (mode_changed) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] btn, input logic spur,
                               input logic inject, input logic [1:0] exp_mode, input int exp_pulses);
    int p0, c0, n, len;
    p0 = pulse_cnt;
    c0 = clear_cnt;
    press = btn;
    spurious = spur;
    tick();
    press = 2'b00;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    spurious = 1'b0;
    checkOutput({tag, "_started"}, {31'd0, busy}, 32'd1);
    len = busy ? 1 : 0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (inject && len == 6) press = 2'b10;
      else if (inject && len == 10) press = 2'b01;
      else press = 2'b00;
      if (busy) len++;
    end
    press = 2'b00;
    tick();
    tick();
    checkOutput({tag, "_mode"}, {30'd0, mode}, {30'd0, exp_mode});
    checkOutput({tag, "_pulses"}, pulse_cnt - p0, exp_pulses);
    checkOutput({tag, "_clears"}, clear_cnt - c0, EXP_CLEARS);
    checkOutput({tag, "_busy_len"}, len, EXP_BUSY);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0, c0, n;
    tick();
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    checkOutput("rst_wn", {31'd0, avm_write_n}, 32'd1);
    checkOutput("rst_addr", {30'd0, avm_address}, 32'd0);
    checkOutput("rst_wdata", avm_writedata, 32'd0);
    checkOutput("rst_mode", {30'd0, mode}, 32'd0);
    checkOutput("rst_pulse", {31'd0, mode_changed}, 32'd0);

    reset = 1'b0;
    tick();
    checkOutput("init_bus", {avm_chipselect, avm_write_n, avm_address, avm_writedata[27:0]},
                {1'b1, 1'b0, 2'd2, 28'h3});
    checkOutput("init_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("idle_cs", {31'd0, avm_chipselect}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_mode", {30'd0, mode}, 32'd0);

    // Cycle-by-cycle view of the first next-button event.
    p0 = pulse_cnt;
    press = 2'b01;
    tick();
    press = 2'b00;
    checkOutput("pre_e0_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("e0_read", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
    tick();
    checkOutput("e1_wait", {avm_chipselect, avm_write_n, avm_address}, {1'b0, 1'b1, 2'd0});
    tick();
    checkOutput("e2_clear", {avm_chipselect, avm_write_n, avm_address, avm_writedata[27:0]},
                {1'b1, 1'b0, 2'd3, 28'h0});
    tick();
    checkOutput("e3_bus", {31'd0, avm_chipselect}, 32'd0);
    checkOutput("e3_mode", {30'd0, mode, mode_changed}, {29'd0, 2'd0, 1'b0});
    tick();
    checkOutput("e4_mode", {30'd0, mode, mode_changed}, {29'd0, 2'd1, 1'b1});
    tick();
    checkOutput("e5_pulse", {31'd0, mode_changed}, 32'd0);
`ifdef BTN_MODE_CTRL_HOLDOFF_EN
    checkOutput("e5_busy", {31'd0, busy}, 32'd1);
`else
    checkOutput("e5_busy", {31'd0, busy}, 32'd0);
`endif
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    checkOutput("first_idle", {31'd0, busy}, 32'd0);
    checkOutput("first_pulses", pulse_cnt - p0, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("ev%0d", i), vecs[i].btn, vecs[i].spur, 1'b0,
                    vecs[i].exp_mode, vecs[i].exp_pulses);
    end

`ifdef BTN_MODE_CTRL_HOLDOFF_EN
    applyStimulus("holdoff", 2'b01, 1'b0, 1'b1, 2'd3, 1);
    checkOutput("holdoff_irq_flushed", {31'd0, irq}, 32'd0);
    applyStimulus("back_to_2", 2'b10, 1'b0, 1'b0, 2'd2, 1);
`endif

    // Reset in the middle of the CLEAR write.
    p0 = pulse_cnt;
    press = 2'b01;
    tick();
    press = 2'b00;
    n = 0;
    while (!(avm_chipselect && !avm_write_n && avm_address == 2'd3) && n < 10) begin
      tick();
      n++;
    end
    checkOutput("clear_reached", {31'd0, avm_chipselect && !avm_write_n}, 32'd1);
    c0 = clear_cnt;
    reset = 1'b1;
    tick();
    checkOutput("rst_clear_bus", {avm_chipselect, avm_write_n, avm_address}, {1'b0, 1'b1, 2'd0});
    checkOutput("rst_clear_mode", {30'd0, mode, mode_changed}, {29'd0, 2'd0, 1'b0});
    checkOutput("rst_clear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    checkOutput("reinit_bus", {avm_chipselect, avm_write_n, avm_address, avm_writedata[27:0]},
                {1'b1, 1'b0, 2'd2, 28'h3});
    tick();
    tick();
    tick();
    checkOutput("reinit_idle", {31'd0, busy}, 32'd0);
    checkOutput("reinit_clears", clear_cnt - c0, 1);
    checkOutput("reinit_mode", {30'd0, mode}, 32'd0);
    checkOutput("reinit_pulses", pulse_cnt - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
